// File: rtl/serial_deframer.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, optional even
// parity, stop bit; good words are held in a one-word register behind valid/ready.
module serial_deframer #(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serialin,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_mis;
    logic              can_load;

    // The holding register can take a new word if empty or drained on this edge.
    assign can_load = ~dout_valid | dout_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            par_mis    <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            if (dout_valid && dout_ready)
                dout_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (serialin) begin
                        state   <= DATA;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        par_mis <= 1'b0;
                    end
                end
                DATA: begin
                    // Shift right so the first (LSB) bit lands in bit 0 after DATA_W shifts.
                    shreg <= {serialin, shreg[DATA_W-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_W - 1))
                        state <= (PARITY_EN != 0) ? PARITY : STOP;
                end
                PARITY: begin
                    par_mis <= (^shreg) ^ serialin;
                    state   <= STOP;
                end
                STOP: begin
                    // Always back to IDLE: the stop bit is never mistaken for a start bit.
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (serialin) begin
                        frame_err  <= 1'b1;
                        parity_err <= par_mis;
                    end else if (par_mis) begin
                        parity_err <= 1'b1;
                    end else if (can_load) begin
                        dout       <= shreg;
                        dout_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_deframer.sv
// Directed bench for serial_deframer: words expected to be delivered are queued
// when their frames are sent and compared when the handshake consumes them.
module tb_serial_deframer;

    localparam int DATA_W    = 8;
    localparam int PARITY_EN = 1;

    logic              clk;
    logic              reset;
    logic              serialin;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              frame_err;
    logic              parity_err;
    logic              overrun;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] sb[$];
    logic prev_fe = 1'b0;
    logic prev_pe = 1'b0;
    logic prev_ov = 1'b0;

    serial_deframer #(.DATA_W(DATA_W), .PARITY_EN(PARITY_EN)) dut (
        .clk        (clk),
        .reset      (reset),
        .serialin   (serialin),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: consume/compare at the falling edge, then step past the rising edge.
    task automatic cycle();
        logic [7:0] exp_w;
        @(negedge clk);
        if (dout_valid && dout_ready) begin
            check("sb_has_word", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_w = sb.pop_front();
                check("dout_word", 32'(dout), 32'(exp_w));
            end
        end
        if (frame_err)  check("frame_err_width",  32'(prev_fe), 32'd0);
        if (parity_err) check("parity_err_width", 32'(prev_pe), 32'd0);
        if (overrun)    check("overrun_width",    32'(prev_ov), 32'd0);
        prev_fe = frame_err;
        prev_pe = parity_err;
        prev_ov = overrun;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        serialin = b;
        cycle();
    endtask

    task automatic idle(input int n);
        serialin = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send_frame(input logic [7:0] data, input logic bad_par,
                              input logic stop_val, input logic drain_at_stop);
        logic saved;
        send_bit(1'b1);
        for (int i = 0; i < DATA_W; i++) send_bit(data[i]);
        send_bit((^data) ^ bad_par);
        saved = dout_ready;
        if (drain_at_stop) dout_ready = 1'b1;
        send_bit(stop_val);
        dout_ready = saved;
    endtask

    task automatic check_flags(input string tag, input logic fe, input logic pe, input logic ov);
        check({tag, "_frame_err"},  32'(frame_err),  32'(fe));
        check({tag, "_parity_err"}, 32'(parity_err), 32'(pe));
        check({tag, "_overrun"},    32'(overrun),    32'(ov));
    endtask

    initial begin
        reset      = 1'b0;
        serialin   = 1'b0;
        dout_ready = 1'b0;
        #2;
        check("rst_dout",       32'(dout),       32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        idle(20);
        check("idle_busy",  32'(busy),       32'd0);
        check("idle_valid", 32'(dout_valid), 32'd0);

        // Abort a frame with an asynchronous reset pulse.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check("midframe_busy", 32'(busy), 32'd1);
        serialin = 1'b0;
        reset    = 1'b0;
        #1;
        check("abort_busy",  32'(busy),       32'd0);
        check("abort_valid", 32'(dout_valid), 32'd0);
        check_flags("abort", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(DATA_W + 4);
        check("post_abort_busy",  32'(busy),       32'd0);
        check("post_abort_valid", 32'(dout_valid), 32'd0);
        check_flags("post_abort", 1'b0, 1'b0, 1'b0);

        // Good frames with the consumer always ready.
        dout_ready = 1'b1;
        sb.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check("3c_valid", 32'(dout_valid), 32'd1);
        check("3c_dout",  32'(dout),       32'h3C);
        check_flags("3c", 1'b0, 1'b0, 1'b0);
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        check("a5_valid", 32'(dout_valid), 32'd1);
        check("a5_dout",  32'(dout),       32'hA5);
        check_flags("a5", 1'b0, 1'b0, 1'b0);
        idle(1);
        check("a5_drained", 32'(dout_valid), 32'd0);

        // Parity error.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        check("perr_valid", 32'(dout_valid), 32'd0);
        check_flags("perr", 1'b0, 1'b1, 1'b0);
        idle(1);
        check_flags("perr_after", 1'b0, 1'b0, 1'b0);

        // Framing error; the 1 stop bit must not restart a frame.
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        check("ferr_valid", 32'(dout_valid), 32'd0);
        check("ferr_busy",  32'(busy),       32'd0);
        check_flags("ferr", 1'b1, 1'b0, 1'b0);
        idle(1);
        check("ferr_no_start", 32'(busy), 32'd0);
        check_flags("ferr_after", 1'b0, 1'b0, 1'b0);

        // Boundary data patterns, back to back.
        sb.push_back(8'h00);
        send_frame(8'h00, 1'b0, 1'b0, 1'b0);
        check("00_dout", 32'(dout), 32'h00);
        sb.push_back(8'hFF);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        check("ff_dout", 32'(dout), 32'hFF);
        sb.push_back(8'h80);
        send_frame(8'h80, 1'b0, 1'b0, 1'b0);
        check("80_dout", 32'(dout), 32'h80);
        idle(2);

        // Backpressure then overrun.
        dout_ready = 1'b0;
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b0, 1'b0);
        check("bp_valid", 32'(dout_valid), 32'd1);
        check("bp_dout",  32'(dout),       32'h11);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0);
        check("ovr_valid", 32'(dout_valid), 32'd1);
        check("ovr_dout",  32'(dout),       32'h11);
        check_flags("ovr", 1'b0, 1'b0, 1'b1);
        idle(3);
        check("bp_hold_dout", 32'(dout), 32'h11);
        dout_ready = 1'b1;
        idle(1);
        dout_ready = 1'b0;
        check("bp_release_valid", 32'(dout_valid), 32'd0);

        // Drain and commit on the same edge.
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b0, 1'b0);
        sb.push_back(8'h33);
        send_frame(8'h33, 1'b0, 1'b0, 1'b1);
        check("dc_valid", 32'(dout_valid), 32'd1);
        check("dc_dout",  32'(dout),       32'h33);
        check_flags("dc", 1'b0, 1'b0, 1'b0);
        dout_ready = 1'b1;
        idle(1);
        check("dc_drained", 32'(dout_valid), 32'd0);
        idle(2);

        check("sb_empty_at_end", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_deframer.md
Name: serial_deframer

Overview:
- Downstream consumer of the serial shift-register stage: samples that stage's serial output on every clk.
- Detects a start bit and assembles DATA_W data bits, LSB first.
- Checks optional even parity and the stop bit.
- Presents each good word on a parallel port with a valid/ready handshake and a one-word holding register.
- Flags framing, parity and overrun errors.

Parameters:
DATA_W, 8, data bits per frame (2..32)
PARITY_EN, 1, 1 = even-parity bit follows data; 0 = no parity bit

Ports:
clk  input  1  rising-edge clock; one serial bit per cycle
reset  input  1  asynchronous, active-low reset
serialin  input  1  serial line from upstream shift register; idles low
dout  output  DATA_W  received word
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  consumer accepts dout when high with dout_valid
frame_err  output  1  one-cycle pulse: stop bit was not 0
parity_err  output  1  one-cycle pulse: parity mismatch (PARITY_EN=1 only)
overrun  output  1  one-cycle pulse: good frame dropped, holding register full
busy  output  1  high while FSM is not IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM to IDLE, bit counter and shift register cleared.
  - dout=0, dout_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0.
  - Reset asserted mid-frame aborts the frame, no flags. After release the FSM waits in IDLE for a new start bit.
- Frame format on serialin, one bit per clk:
  - idle level 0; start bit 1.
  - DATA_W data bits, LSB first.
  - parity bit (present iff PARITY_EN=1), chosen so the count of ones over data+parity is even.
  - stop bit 0.
- FSM states IDLE, DATA, PARITY, STOP:
  - IDLE: serialin=1 at edge t -> DATA, counter cleared. serialin=0 stays IDLE.
  - DATA: shift in serialin at edges t+1..t+DATA_W. Data bit i is sampled at t+1+i. After the last bit -> PARITY if PARITY_EN, else STOP.
  - PARITY: sample at t+DATA_W+1; store mismatch = XOR(data) ^ bit; -> STOP.
  - STOP: sample at t+DATA_W+1+PARITY_EN; -> IDLE unconditionally.
  - The stop bit is never taken as a start bit. A start bit may arrive in the cycle immediately after the stop bit (back-to-back frames, no idle gap required).
- Commit, evaluated at the STOP sampling edge:
  - Good frame (stop=0, no parity mismatch), holding register empty or being drained this edge (dout_valid & dout_ready): load dout, dout_valid=1 from the next cycle. Latency from the last serial bit sampled to dout_valid high is one cycle.
  - Good frame, holding register full and not drained: keep the old dout, drop the new word, pulse overrun for one cycle.
  - stop=1: pulse frame_err; word not committed. parity_err also pulses if parity mismatched.
  - Parity mismatch with stop=0: pulse parity_err only; word not committed.
- Handshake:
  - dout_valid stays high and dout stays stable until the edge where dout_ready=1.
  - That edge clears dout_valid unless a new word commits on the same edge, in which case dout_valid stays 1 and dout takes the new word.
  - dout_ready while dout_valid=0 has no effect.
- Error flags are registered and high for exactly one cycle, aligned with the cycle dout_valid would have risen.
- busy=1 in DATA, PARITY and STOP.

Test Plan:
- Reset mid-frame:
  - Stimulus: reset low, then release; serialin stays 0 for 20 cycles; then start 1 with 3 data bits, then reset=0 for one cycle.
  - Required: all outputs 0, busy 0. No flags, dout_valid 0. A following full frame of 0x3C is received correctly.
- Good frame, PARITY_EN=1:
  - Stimulus: dout_ready=1; serialin = 1, 1,0,1,0,0,1,0,1, 0, 0 (0xA5, parity 0, stop 0).
  - Required: dout=0xA5 with dout_valid high one cycle after the stop sample, no error flags.
- Parity error:
  - Stimulus: same frame with parity bit 1.
  - Required: parity_err pulses one cycle, dout_valid stays 0, frame_err 0.
- Framing error:
  - Stimulus: 0x5A frame with stop bit 1, next cycle serialin 0.
  - Required: frame_err pulses, FSM to IDLE, no false start.
- Backpressure and overrun:
  - Stimulus: dout_ready=0; back-to-back frames 0x11 then 0x22.
  - Required: dout stays 0x11 with valid held; overrun pulses at the end of 0x22.
  - Then dout_ready=1 for one cycle: dout_valid goes 0.
- Simultaneous drain and commit:
  - Stimulus: dout=0x11 valid; frame 0x33 completes on the same edge dout_ready=1.
  - Required: dout_valid stays 1, dout=0x33, no overrun.
